// File: rtl/spectro_pkg.sv
// Shared constants and the channel-word mux helper for the spectrometer readout path.
package spectro_pkg;

    localparam int SEQ_DWELL = 12;
    localparam int NUM_CH    = 16;
    localparam int DATA_W    = SEQ_DWELL - 1;
    localparam int SEL_W     = 4;

    localparam logic [SEL_W:0] FULL_CNT  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W:0] TALLY_MAX = '1;

    // Indices with no matching word (sel beyond NUM_CH-1) yield an all-zero word.
    function automatic logic [DATA_W-1:0] word_of(
        input logic [NUM_CH*DATA_W-1:0] data,
        input logic [SEL_W-1:0]         idx
    );
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == k[SEL_W-1:0]) begin
                w = data[k*DATA_W +: DATA_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: MSB first, zero fill, flags the MSB cycle.
module piso_shift_reg #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              sout,
    output logic              valid,
    output logic              first
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_d, shift_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              first_d, first_q;

    // Next-state: a load always wins over an in-progress shift.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        if (load) begin
            shift_d = din;
            cnt_d   = CNT_W'(DATA_W);
            first_d = 1'b1;
        end else if (cnt_q != '0) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Shifter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign sout  = shift_q[DATA_W-1];
    assign valid = (cnt_q != '0);
    assign first = first_q;

endmodule

// File: rtl/channel_serializer.sv
// Serialises the sequencer-selected channel word and publishes a per-frame XOR checksum and word tally.
module channel_serializer
    import spectro_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sl,
    input  logic                     frame_rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     word_start,
    output logic                     frame_start,
    output logic [SEL_W-1:0]         chan_id,
    output logic [DATA_W-1:0]        csum,
    output logic                     csum_valid,
    output logic [SEL_W:0]           word_cnt,
    output logic                     frame_err,
    output logic                     overrun
);

    logic [DATA_W-1:0] word_s;
    logic              busy_s;

    logic [DATA_W-1:0] acc_d, acc_q, csum_d, csum_q;
    logic [SEL_W:0]    tally_d, tally_q, word_cnt_d, word_cnt_q;
    logic [SEL_W-1:0]  chan_id_d, chan_id_q;
    logic              csum_valid_d, csum_valid_q;
    logic              frame_err_d, frame_err_q;
    logic              overrun_d, overrun_q;
    logic              frame_start_d, frame_start_q;

    assign word_s = word_of(ch_data, sel);

    piso_shift_reg #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (sl),
        .din   (word_s),
        .sout  (sout),
        .valid (busy_s),
        .first (word_start)
    );

    // Frame bookkeeping; on a frame_rst+sl coincidence the new word opens the next frame.
    always_comb begin
        acc_d         = acc_q;
        tally_d       = tally_q;
        csum_d        = csum_q;
        word_cnt_d    = word_cnt_q;
        csum_valid_d  = 1'b0;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q | (sl & busy_s);
        chan_id_d     = chan_id_q;
        frame_start_d = 1'b0;
        if (sl) begin
            chan_id_d     = sel;
            frame_start_d = (sel == '0);
        end else begin
            chan_id_d     = chan_id_q;
            frame_start_d = 1'b0;
        end
        if (frame_rst) begin
            csum_d       = acc_q;
            word_cnt_d   = tally_q;
            csum_valid_d = 1'b1;
            frame_err_d  = (tally_q != FULL_CNT);
            if (sl) begin
                acc_d   = word_s;
                tally_d = (SEL_W+1)'(1);
            end else begin
                acc_d   = '0;
                tally_d = '0;
            end
        end else if (sl) begin
            acc_d   = acc_q ^ word_s;
            tally_d = (tally_q == TALLY_MAX) ? tally_q : tally_q + (SEL_W+1)'(1);
        end else begin
            acc_d   = acc_q;
            tally_d = tally_q;
        end
    end

    // Bookkeeping and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            tally_q       <= '0;
            csum_q        <= '0;
            word_cnt_q    <= '0;
            csum_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            chan_id_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            tally_q       <= tally_d;
            csum_q        <= csum_d;
            word_cnt_q    <= word_cnt_d;
            csum_valid_q  <= csum_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            chan_id_q     <= chan_id_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sout_valid  = busy_s;
    assign frame_start = frame_start_q;
    assign chan_id     = chan_id_q;
    assign csum        = csum_q;
    assign csum_valid  = csum_valid_q;
    assign word_cnt    = word_cnt_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_channel_serializer.sv
// Randomised and directed bench for channel_serializer against a queue-based reference model.
module tb_channel_serializer;
    import spectro_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [SEL_W-1:0]         sel;
    logic                     sl;
    logic                     frame_rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     sout, sout_valid, word_start, frame_start;
    logic [SEL_W-1:0]         chan_id;
    logic [DATA_W-1:0]        csum;
    logic                     csum_valid;
    logic [SEL_W:0]           word_cnt;
    logic                     frame_err, overrun;

    logic [DATA_W-1:0] words [NUM_CH];

    // Reference model: bits still to appear on sout, and every word loaded in the open frame.
    bit                exp_bits [$];
    logic [DATA_W-1:0] frame_words [$];
    logic              m_ws, m_fs, m_cv, m_err, m_ovr;
    logic [SEL_W-1:0]  m_chan;
    logic [DATA_W-1:0] m_csum;
    logic [SEL_W:0]    m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    channel_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .sl          (sl),
        .frame_rst   (frame_rst),
        .ch_data     (ch_data),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .word_start  (word_start),
        .frame_start (frame_start),
        .chan_id     (chan_id),
        .csum        (csum),
        .csum_valid  (csum_valid),
        .word_cnt    (word_cnt),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Flatten the word table onto the channel bus.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k*DATA_W +: DATA_W] = words[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_bits.delete();
        frame_words.delete();
        m_ws = 1'b0; m_fs = 1'b0; m_cv = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
        m_chan = '0; m_csum = '0; m_cnt = '0;
    endtask

    task automatic model_edge(input logic s, input logic [SEL_W-1:0] idx, input logic fr);
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] x;
        int                limit;
        w     = words[idx];
        limit = (1 << (SEL_W + 1)) - 1;
        if (fr) begin
            x = '0;
            foreach (frame_words[i]) x = x ^ frame_words[i];
            m_csum = x;
            m_cnt  = (frame_words.size() > limit) ? (SEL_W+1)'(limit) : (SEL_W+1)'(frame_words.size());
            m_err  = (frame_words.size() != NUM_CH);
            m_cv   = 1'b1;
            frame_words.delete();
        end else begin
            m_cv = 1'b0;
        end
        if (s) begin
            if (exp_bits.size() != 0) m_ovr = 1'b1;
            exp_bits.delete();
            for (int b = DATA_W - 1; b >= 0; b--) exp_bits.push_back(w[b]);
            m_ws   = 1'b1;
            m_fs   = (idx == '0);
            m_chan = idx;
            frame_words.push_back(w);
        end else begin
            if (exp_bits.size() != 0) void'(exp_bits.pop_front());
            m_ws = 1'b0;
            m_fs = 1'b0;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ":sout_valid"},  32'(sout_valid),  32'(exp_bits.size() != 0));
        check({ctx, ":sout"},        32'(sout),        32'((exp_bits.size() != 0) ? exp_bits[0] : 1'b0));
        check({ctx, ":word_start"},  32'(word_start),  32'(m_ws));
        check({ctx, ":frame_start"}, 32'(frame_start), 32'(m_fs));
        check({ctx, ":chan_id"},     32'(chan_id),     32'(m_chan));
        check({ctx, ":csum"},        32'(csum),        32'(m_csum));
        check({ctx, ":csum_valid"},  32'(csum_valid),  32'(m_cv));
        check({ctx, ":word_cnt"},    32'(word_cnt),    32'(m_cnt));
        check({ctx, ":frame_err"},   32'(frame_err),   32'(m_err));
        check({ctx, ":overrun"},     32'(overrun),     32'(m_ovr));
    endtask

    task automatic tick(input string ctx, input logic s, input logic [SEL_W-1:0] idx, input logic fr);
        sl        = s;
        sel       = idx;
        frame_rst = fr;
        @(posedge clk);
        model_edge(s, idx, fr);
        #1;
        compare_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) tick(ctx, 1'b0, '0, 1'b0);
    endtask

    task automatic run_frame(input string ctx, input int n);
        for (int k = 0; k < n; k++) begin
            tick(ctx, 1'b1, SEL_W'(k), 1'b0);
            idle(ctx, SEQ_DWELL - 1);
        end
        tick(ctx, 1'b0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; sl = 1'b0; frame_rst = 1'b0; sel = '0;
        for (int k = 0; k < NUM_CH; k++) words[k] = DATA_W'($urandom);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;

        // Single word 0x5A5 on channel 3.
        words[3] = 11'h5A5;
        tick("one_word", 1'b1, 4'd3, 1'b0);
        check("one_word:msb", 32'(sout), 32'd1);
        idle("one_word", 12);

        // Full frame with word k = k*0x81.
        for (int k = 0; k < NUM_CH; k++) words[k] = DATA_W'(k * 32'h81);
        run_frame("full", NUM_CH);
        idle("full", 2);

        // Short frame, then a good frame clears frame_err.
        run_frame("short", 5);
        check("short:cnt", 32'(word_cnt), 32'd5);
        run_frame("recover", NUM_CH);

        // Coincident sl and frame_rst.
        words[1] = 11'h001;
        words[2] = 11'h002;
        tick("coin", 1'b1, 4'd1, 1'b0);
        idle("coin", SEQ_DWELL - 1);
        tick("coin", 1'b1, 4'd2, 1'b0);
        idle("coin", SEQ_DWELL - 1);
        tick("coin", 1'b1, 4'd7, 1'b1);
        check("coin:csum3", 32'(csum), 32'h003);
        check("coin:cnt2", 32'(word_cnt), 32'd2);
        idle("coin", SEQ_DWELL - 1);
        tick("coin_next", 1'b0, '0, 1'b1);

        // Overrun: second load four cycles into a word.
        tick("ovr", 1'b1, 4'd2, 1'b0);
        idle("ovr", 3);
        tick("ovr", 1'b1, 4'd5, 1'b0);
        idle("ovr", 13);
        check("ovr:sticky", 32'(overrun), 32'd1);

        // Tally saturation: back-to-back loads past the counter range.
        for (int i = 0; i < 34; i++) tick("sat", 1'b1, SEL_W'($urandom_range(0, NUM_CH-1)), 1'b0);
        tick("sat", 1'b0, '0, 1'b1);
        check("sat:cnt", 32'(word_cnt), 32'd31);
        idle("sat", 12);

        // Asynchronous reset at bit 5 of a word.
        tick("rst_mid", 1'b1, 4'd9, 1'b0);
        idle("rst_mid", 5);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        reset = 1'b0;
        idle("rst_after", 4);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) words[$urandom_range(0, NUM_CH-1)] = DATA_W'($urandom);
            tick("rand", 1'($urandom_range(0, 9) == 0), SEL_W'($urandom_range(0, NUM_CH-1)),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
